// File: rtl/float_divider.sv
// rtl/float_divider.sv - iterative restoring-radix-2 float divider (FLOAT_DIV_ROUND_NEAREST_EN enables round-to-nearest)
module float_divider #(
  parameter int E_bit = 8,
  parameter int F_bit = 23,
  parameter int E_ref = (1 << (E_bit - 1)) - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [E_bit+F_bit:0]     div_a,
  input  logic [E_bit+F_bit:0]     div_b,
  output logic                     busy,
  output logic                     done,
  output logic [E_bit+F_bit:0]     out_a,
  output logic                     div_zero
);

  localparam int W  = E_bit + F_bit + 1;
`ifdef FLOAT_DIV_ROUND_NEAREST_EN
  // One extra quotient bit serves as the guard bit for rounding.
  localparam int QW = F_bit + 3;
`else
  localparam int QW = F_bit + 2;
`endif
  localparam int CW = $clog2(QW + 1);
  localparam int EW = E_bit + 2;

  // Exponent arithmetic is done modulo 2^EW; the MSB acts as the sign.
  localparam logic [EW-1:0] E_REF_X   = EW'(E_ref);
  localparam logic [EW-1:0] ONE_X     = EW'(1);
  localparam logic [EW-1:0] EXP_MAX_X = {2'b00, {E_bit{1'b1}}};
  localparam logic [CW-1:0] CNT_LOAD  = CW'(QW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    ITER   = 2'd2,
    NORM   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NAN  = 2'd0,
    CLS_DZ   = 2'd1,
    CLS_ZERO = 2'd2,
    CLS_NORM = 2'd3
  } cls_t;

  state_t            state_q, state_d;
  logic [W-1:0]      a_reg, b_reg;
  logic              sign_r;
  logic [EW-1:0]     e_r;
  logic [F_bit:0]    mb_r;
  logic [F_bit+1:0]  rem;
  logic [QW-1:0]     q;
  logic [CW-1:0]     cnt;
  cls_t              cls_r;

  // Operand fields of the captured inputs.
  logic              sa, sb;
  logic [E_bit-1:0]  ea, eb;
  logic [F_bit-1:0]  fa, fb;
  assign sa = a_reg[W-1];
  assign sb = b_reg[W-1];
  assign ea = a_reg[W-2:F_bit];
  assign eb = b_reg[W-2:F_bit];
  assign fa = a_reg[F_bit-1:0];
  assign fb = b_reg[F_bit-1:0];

  // Restoring division step: subtract when the remainder covers the divisor.
  logic              rem_ge;
  logic [F_bit+1:0]  rem_sub;
  logic [F_bit+1:0]  rem_nxt;
  always_comb begin
    rem_ge  = (rem >= {1'b0, mb_r});
    rem_sub = rem - {1'b0, mb_r};
    rem_nxt = rem_ge ? {rem_sub[F_bit:0], 1'b0} : {rem[F_bit:0], 1'b0};
  end

  // Operand classification, priority NaN/Inf > zero divisor > zero dividend.
  cls_t cls_n;
  always_comb begin
    cls_n = CLS_NORM;
    if ((ea == {E_bit{1'b1}}) || (eb == {E_bit{1'b1}}))
      cls_n = CLS_NAN;
    else if (eb == '0)
      cls_n = CLS_DZ;
    else if (ea == '0)
      cls_n = CLS_ZERO;
  end

  // Normalise the quotient, apply optional rounding and range checks.
  logic [F_bit-1:0] frac_n;
  logic [EW-1:0]    exp_n;
  logic             ovf, unf;
  logic [W-1:0]     res;
`ifdef FLOAT_DIV_ROUND_NEAREST_EN
  logic             guard;
  logic [F_bit:0]   frac_sum;
`endif
  always_comb begin
    frac_n = '0;
    exp_n  = e_r;
`ifdef FLOAT_DIV_ROUND_NEAREST_EN
    guard    = 1'b0;
    if (q[QW-1]) begin
      frac_n = q[F_bit+1:2];
      guard  = q[1];
    end else begin
      frac_n = q[F_bit:1];
      guard  = q[0];
      exp_n  = e_r - ONE_X;
    end
    frac_sum = {1'b0, frac_n} + {{F_bit{1'b0}}, guard};
    frac_n   = frac_sum[F_bit-1:0];
    if (frac_sum[F_bit])
      exp_n = exp_n + ONE_X;
`else
    if (q[QW-1]) begin
      frac_n = q[F_bit:1];
    end else begin
      frac_n = q[F_bit-1:0];
      exp_n  = e_r - ONE_X;
    end
`endif
    ovf = !exp_n[EW-1] && (exp_n >= EXP_MAX_X);
    unf = exp_n[EW-1] || (exp_n == '0);
    res = {sign_r, exp_n[E_bit-1:0], frac_n};
    case (cls_r)
      CLS_NAN:  res = {sign_r, {E_bit{1'b1}}, {{(F_bit-1){1'b0}}, 1'b1}};
      CLS_DZ:   res = {sign_r, {E_bit{1'b1}}, {F_bit{1'b0}}};
      CLS_ZERO: res = {sign_r, {(W-1){1'b0}}};
      default: begin
        if (ovf)
          res = {sign_r, {E_bit{1'b1}}, {{(F_bit-1){1'b0}}, 1'b1}};
        else if (unf)
          res = {sign_r, {(W-1){1'b0}}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = UNPACK;
      UNPACK:  state_d = ITER;
      ITER:    if (cnt == '0) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and handshake registers, stepped by the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sign_r   <= 1'b0;
      e_r      <= '0;
      mb_r     <= '0;
      rem      <= '0;
      q        <= '0;
      cnt      <= '0;
      cls_r    <= CLS_NAN;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_a    <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_reg <= div_a;
            b_reg <= div_b;
            busy  <= 1'b1;
          end
        end
        UNPACK: begin
          sign_r <= sa ^ sb;
          e_r    <= {2'b00, ea} - {2'b00, eb} + E_REF_X;
          mb_r   <= {1'b1, fb};
          rem    <= {1'b0, 1'b1, fa};
          q      <= '0;
          cnt    <= CNT_LOAD;
          cls_r  <= cls_n;
        end
        ITER: begin
          rem <= rem_nxt;
          q   <= {q[QW-2:0], rem_ge};
          if (cnt != '0)
            cnt <= cnt - CW'(1);
        end
        NORM: begin
          out_a    <= res;
          div_zero <= (cls_r == CLS_DZ);
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_divider.sv
// tb/tb_float_divider.sv - scoreboard bench for float_divider
module tb_float_divider;

`ifdef FLOAT_DIV_ROUND_NEAREST_EN
  localparam int LAT = 28;
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam int LAT = 27;
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] div_a = '0;
  logic [31:0] div_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] out_a;

  typedef struct {
    logic [31:0] o;
    logic        dz;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  float_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .div_a    (div_a),
    .div_b    (div_b),
    .busy     (busy),
    .done     (done),
    .out_a    (out_a),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every done against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) begin
        checks++;
        if (done) begin
          errors++;
          $display("FAIL done_width got done=1 want done=0 at cyc %0d", cyc);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done=1 want no done at cyc %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if (out_a !== mon_e.o) begin
            errors++;
            $display("FAIL out_a got %h want %h", out_a, mon_e.o);
          end
          checks++;
          if (div_zero !== mon_e.dz) begin
            errors++;
            $display("FAIL div_zero got %b want %b", div_zero, mon_e.dz);
          end
          checks++;
          if (cyc != mon_e.c) begin
            errors++;
            $display("FAIL latency got done at cyc %0d want %0d", cyc, mon_e.c);
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done got %b want 0", busy);
          end
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_o,
                       input logic dz, input bit push, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_wait", 32'(busy), 32'd0);
    div_a = a;
    div_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    div_a = $urandom;
    div_b = $urandom;
    if (push) sb.push_back('{exp_o, dz, acc + LAT});
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int acc;
  int t;

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_a", out_a, 32'h0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function and special values.
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1, acc);
    issue(32'h3F800000, 32'h40400000, THIRD,        1'b0, 1'b1, acc);
    issue(32'hBF800000, 32'h3F000000, 32'hC0000000, 1'b0, 1'b1, acc);
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b1, acc);
    issue(32'h7F800000, 32'h3F800000, 32'h7F800001, 1'b0, 1'b1, acc);
    issue(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1, acc);
    issue(32'h7F000000, 32'h00800000, 32'h7F800001, 1'b0, 1'b1, acc);
    issue(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b1, acc);

    // Start pulses while busy are ignored.
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1, acc);
    wait_until(acc + 4);
    div_a = 32'h3F800000; div_b = 32'h00000000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_until(acc + 25);
    div_a = 32'h3F800000; div_b = 32'h00000000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;

    // Start held during the done cycle is taken on the following edge.
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done), 32'd1);
    div_a = 32'h3F800000; div_b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    sb.push_back('{THIRD, 1'b0, acc + LAT});
    check("busy_after_done_start", 32'(busy), 32'd1);

    // Asynchronous reset mid-operation abandons the work.
    issue(32'h40C00000, 32'h40000000, 32'h0, 1'b0, 1'b0, acc);
    wait_until(acc + 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_out_a", out_a, 32'h0);
    check("arst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1, acc);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
